result_streamer: RTL
====================

// Module: result_streamer
// PURPOSE
//  Downstream drain stage for top_processor. On the rising edge of done_i it reads
//  result memory words 0..COUNT-1 through the result-RAM port (1-cycle read latency).
//  Words leave on a valid/ready stream with last marking the final word.
//  A 2-entry output FIFO absorbs backpressure without losing or duplicating words.
// PARAMETERS
//  DATA_WIDTH  32    result word width (match `DATA_WIDTH)
//  ADDR_WIDTH  10    result RAM address width (match `ADDR_WIDTH)
//  COUNT       1024  words per drain, 1..2**ADDR_WIDTH
// PORTS
//  CLK                input   1           clock, all logic on posedge
//  RST                input   1           synchronous reset, active-low
//  done_i             input   1           top_processor done_o; a rising edge starts a drain
//  addr_data_o        output  ADDR_WIDTH  result RAM address
//  ena_data_result_o  output  1           result RAM enable, one read per asserted cycle
//  wea_data_result_o  output  1           result RAM write enable, tied 0
//  data_result_i      input   DATA_WIDTH  RAM read data, valid 1 cycle after ena
//  m_data_o           output  DATA_WIDTH  stream data
//  m_valid_o          output  1           stream valid
//  m_last_o           output  1           high with the word at address COUNT-1
//  m_ready_i          input   1           stream ready; a beat transfers when valid&ready
//  busy_o             output  1           high from accept of done edge until last beat
//  drained_o          output  1           1-cycle pulse on the cycle after the last beat
// BEHAVIOUR
//  Reset (RST==0 at posedge): state IDLE; all outputs 0; FIFO emptied; in-flight cleared;
//    done_i history register cleared to 0. Reset mid-drain aborts at once with no further reads.
//  Edge detect: done_q <= done_i every cycle; start = done_i & ~done_q.
//  FSM:
//    IDLE  -> READ on start: rd_addr<=0, issued<=0, busy_o<=1.
//    READ  -> issue one read per cycle while allowed; -> FLUSH after the read at COUNT-1.
//    FLUSH -> wait until in-flight==0 and FIFO empty -> IDLE; drained_o pulses 1 cycle.
//    start while not IDLE is ignored. done_i held high after a drain does not restart;
//    it must fall, then rise again.
//  Read issue rule: allowed iff fifo_count + inflight - pop < 2 (pop = m_valid_o&m_ready_i).
//    At most 2 words are ever held or in flight. ena_data_result_o=1 and
//    addr_data_o=rd_addr in the issue cycle. rd_addr increments per issue and never
//    exceeds COUNT-1.
//  inflight (0/1) = ena registered. When inflight==1, data_result_i is pushed into the FIFO
//    with a tag last=(its address==COUNT-1).
//  FIFO: 2 entries, registered head drives m_data_o/m_last_o; m_valid_o = ~empty.
//    Push and pop in the same cycle are both honoured. Data/last stay stable while
//    valid & ~ready.
//  Latency: start seen at edge E0 -> addr 0 read in the cycle after E0 -> first m_valid_o
//    3 cycles after E0. With m_ready_i held 1: COUNT contiguous beats, 1 word/cycle.
//  busy_o falls and drained_o rises on the cycle after the last beat transfers.
//  COUNT==1: single beat with m_last_o=1.
// TESTING
//  1 ready=1, COUNT=1024, RAM[i]=i*3: done 0->1 -> first valid 3 cycles later; 1024
//    contiguous beats with data=i*3; last only at beat 1023; drained_o 1 cycle; busy_o low.
//  2 ready low cycles 5..14 of the drain -> valid held, data stable; at most 2 reads
//    outstanding; all 1024 words in order, none duplicated.
//  3 random 50% ready, COUNT=16 -> 16 beats in order, last at beat 15, scoreboard clean.
//  4 RST=0 at beat 500 -> all outputs 0 the next cycle, no ena. A new done edge then gives
//    a full drain from addr 0.
//  5 done_i held 1 after drain -> no restart. Extra done pulse mid-drain -> ignored; count
//    stays 1024.
//  6 COUNT=1 -> one beat, m_last_o=1, drained_o the following cycle; wea_data_result_o always 0.

Source files
------------

// File: rtl/result_streamer.sv
`default_nettype none
// ============================================================================
// result_streamer : drains COUNT result-RAM words onto a valid/ready stream
//                   after a rising edge of done_i, via a 2-entry output FIFO.
// Revision        : 1.0
// ============================================================================
module result_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int COUNT      = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  done_i,
    output logic [ADDR_WIDTH-1:0] addr_data_o,
    output logic                  ena_data_result_o,
    output logic                  wea_data_result_o,
    input  logic [DATA_WIDTH-1:0] data_result_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic                  busy_o,
    output logic                  drained_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;
    logic                    busy_q, busy_d;
    logic                    drained_q, drained_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;
    logic [DATA_WIDTH-1:0]   head_data_q, head_data_d;
    logic                    head_last_q, head_last_d;
    logic [DATA_WIDTH-1:0]   tail_data_q, tail_data_d;
    logic                    tail_last_q, tail_last_d;

    logic                    start;
    logic                    pop;
    logic                    push;
    logic                    issue;
    logic [2:0]              occupancy;

    assign m_valid_o         = (fifo_cnt_q != 2'd0);
    assign m_data_o          = head_data_q;
    assign m_last_o          = head_last_q;
    assign ena_data_result_o = issue;
    assign addr_data_o       = issue ? rd_addr_q : '0;
    assign wea_data_result_o = 1'b0;
    assign busy_o            = busy_q;
    assign drained_o         = drained_q;

    // Control: edge detect, read issue throttle and drain sequencing
    always_comb begin
        done_d          = done_i;
        start           = done_i & ~done_q;
        pop             = m_valid_o & m_ready_i;
        push            = inflight_q;
        // Words held plus words in flight after this cycle's pop must stay below 2
        occupancy       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue           = (state_q == ST_READ) && (occupancy < 3'd2);
        state_d         = state_q;
        rd_addr_d       = rd_addr_q;
        busy_d          = busy_q;
        drained_d       = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue && (rd_addr_q == LAST_ADDR);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_READ;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_READ: begin
                if (issue) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = ST_FLUSH;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_FLUSH: begin
                // The tagged last word leaving means nothing remains in flight
                if (pop && m_last_o) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    drained_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-entry FIFO with the head held in dedicated registers
    always_comb begin
        fifo_cnt_d  = fifo_cnt_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;

        case ({push, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) begin
                    head_data_d = data_result_i;
                    head_last_d = inflight_last_q;
                    fifo_cnt_d  = 2'd1;
                end else begin
                    tail_data_d = data_result_i;
                    tail_last_d = inflight_last_q;
                    fifo_cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                head_data_d = tail_data_q;
                head_last_d = tail_last_q;
                fifo_cnt_d  = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    head_data_d = data_result_i;
                    head_last_d = inflight_last_q;
                end else begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    tail_data_d = data_result_i;
                    tail_last_d = inflight_last_q;
                end
            end
            default: begin
                fifo_cnt_d = fifo_cnt_q;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q         <= ST_IDLE;
            done_q          <= 1'b0;
            rd_addr_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            drained_q       <= 1'b0;
            fifo_cnt_q      <= 2'd0;
            head_data_q     <= '0;
            head_last_q     <= 1'b0;
            tail_data_q     <= '0;
            tail_last_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            done_q          <= done_d;
            rd_addr_q       <= rd_addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            drained_q       <= drained_d;
            fifo_cnt_q      <= fifo_cnt_d;
            head_data_q     <= head_data_d;
            head_last_q     <= head_last_d;
            tail_data_q     <= tail_data_d;
            tail_last_q     <= tail_last_d;
        end
    end

endmodule
`default_nettype wire
